// File: rtl/ram_req_ctrl_if.sv
// Request/response channel bundle between a requester and ram_req_ctrl.
//
// Handshake: a transfer happens at a rising clk edge where valid and ready
// are both 1. A source holding valid=1 keeps its payload stable until that
// edge, and valid never depends combinationally on ready. This holds for
// both channels: req_* (requester -> controller) and rsp_* (controller ->
// consumer).
interface ram_req_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Single-master controller for a tri-state RAM. Turns read/write requests
// into addr / wr_en / rd_en / shared-data-bus cycles and returns read data
// on a backpressurable response channel. The bus is driven only in WR, and
// wr_en/rd_en are decoded from mutually exclusive states, so contention is
// impossible by construction.
module ram_req_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 64,
  parameter int RD_WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  ram_req_ctrl_if.slave     req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // The wait counter is 4 bits wide, so larger wait settings cannot work.
  if (RD_WAIT_CYC < 0 || RD_WAIT_CYC > 15) begin : g_bad_rd_wait
    $error("ram_req_ctrl: RD_WAIT_CYC must be in 0..15");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam bit         HAS_WAIT  = (RD_WAIT_CYC > 0);
  localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(RD_WAIT_CYC - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              req_ready_c;
  logic              accept;

  // Ready only in IDLE and never while reset is held.
  assign req_ready_c = rst && (state_q == IDLE);
  assign accept      = req.req_valid && req_ready_c;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request copies and captured read data; req_* may change after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
      end
      if (state_q == RD_CAP) begin
        rdata_q <= ram_data;
      end
    end
  end

  // Next-state logic: reads walk RD_REQ -> [RD_WAIT x N] -> RD_CAP -> RSP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req.req_we ? WR : RD_REQ;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD_REQ: begin
        if (HAS_WAIT) begin
          state_d = RD_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RD_CAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_CAP: begin
        state_d = RSP;
      end
      RSP: begin
        if (req.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so rsp_valid never
  // follows rsp_ready combinationally.
  assign req.req_ready = req_ready_c;
  assign req.rsp_valid = (state_q == RSP);
  assign req.rsp_rdata = rdata_q;
  assign ram_addr      = addr_q;
  assign ram_wr_en     = (state_q == WR);
  assign ram_rd_en     = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == RD_CAP);
  assign ram_data      = (state_q == WR) ? wdata_q : {DATA_W{1'bz}};
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: two instances (no read wait, and 3 wait cycles),
// each with a small tri-state RAM model on its bus. A reference memory
// predicts read data; monitors check responses, write cycles, latency,
// rd_en pulse length and enable exclusivity.
module tb_ram_req_ctrl;
  localparam int AW = 8;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- stimulus and observed signals ----------------
  logic [1:0]         req_valid, req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  bit                 rr_rand[2];
  bit                 rr_val[2];

  logic [1:0]         req_ready_w, rsp_valid_w, wr_w, rd_w, busy_w;
  logic [1:0][DW-1:0] rdata_w;
  logic [1:0][AW-1:0] raddr_w;

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0]    model_mem[2][256];
  logic [DW-1:0]    exp_q[2][$];
  int               acc_q[2][$];
  logic [AW+DW-1:0] wr_exp_q[2][$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = (g == 0) ? 0 : 3;
    ram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    wire  [DW-1:0] ram_data;
    logic [DW-1:0] ram_mem[256];
    logic [DW-1:0] ram_out_q;
    logic [2:0]    dbg_state;
    logic          rsp_rdy;
    bit            prev_v;
    int            run;
    bit            aborted;

    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.rsp_ready  = rsp_rdy;
    assign req_ready_w[g] = bus.req_ready;
    assign rsp_valid_w[g] = bus.rsp_valid;
    assign rdata_w[g]     = bus.rsp_rdata;

    ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT_CYC(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (bus),
      .ram_addr  (raddr_w[g]),
      .ram_wr_en (wr_w[g]),
      .ram_rd_en (rd_w[g]),
      .ram_data  (ram_data),
      .busy      (busy_w[g]),
      .dbg_state (dbg_state)
    );

    // Tri-state RAM: stores on wr_en, loads its output register on rd_en,
    // and drives the bus whenever rd_en is high.
    always @(posedge clk) begin
      if (wr_w[g]) ram_mem[raddr_w[g]] <= ram_data;
      if (rd_w[g]) ram_out_q <= ram_mem[raddr_w[g]];
    end
    assign ram_data = rd_w[g] ? ram_out_q : {DW{1'bz}};

    // Consumer readiness: fixed level or random backpressure.
    initial begin
      rsp_rdy = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        rsp_rdy = rr_rand[g] ? ($urandom_range(0, 2) != 0) : rr_val[g];
      end
    end

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (!rst) aborted = 1'b1;
      if (rst) begin
        chk("en_overlap", 64'(wr_w[g] & rd_w[g]), 64'd0);
        if (wr_w[g]) begin
          if (wr_exp_q[g].size() == 0) begin
            fail("spurious_write");
          end else begin
            e = wr_exp_q[g].pop_front();
            chk("wr_addr", 64'(raddr_w[g]), 64'(e[AW+DW-1:DW]));
            chk("wr_bus", ram_data, e[DW-1:0]);
          end
        end
        if (rsp_valid_w[g]) begin
          if (exp_q[g].size() == 0) begin
            if (!prev_v) fail("spurious_rsp");
          end else begin
            if (!prev_v) chk("rsp_latency", 64'(cyc - acc_q[g][0]), 64'(2 + W));
            chk("rsp_rdata", rdata_w[g], exp_q[g][0]);
            chk("ready_in_rsp", 64'(req_ready_w[g]), 64'd0);
            if (rsp_rdy) begin
              void'(exp_q[g].pop_front());
              void'(acc_q[g].pop_front());
            end
          end
        end
      end
      if (rd_w[g]) begin
        run++;
      end else begin
        if (run > 0 && !aborted) chk("rd_en_len", 64'(run), 64'(W + 2));
        run     = 0;
        aborted = 1'b0;
      end
      prev_v = rsp_valid_w[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u);
    req_valid[u] = 1'b0;
  endtask

  // Presents a request and returns one cycle after it is accepted.
  // acc is the cycle count right after the accepting edge.
  task automatic send(input int u, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input bit track, output int acc);
    int n;
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = data;
    n = 0;
    while (!req_ready_w[u] && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      fail("accept_timeout");
      req_valid[u] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      if (we) begin
        model_mem[u][addr] = data;
        wr_exp_q[u].push_back({addr, data});
      end else begin
        exp_q[u].push_back(model_mem[u][addr]);
        acc_q[u].push_back(acc);
      end
    end
    step();
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    while ((exp_q[u].size() != 0 || wr_exp_q[u].size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  task automatic chk_reset_outputs(input int u);
    chk("rst_req_ready", 64'(req_ready_w[u]), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_w[u]), 64'd0);
    chk("rst_wr_en", 64'(wr_w[u]), 64'd0);
    chk("rst_rd_en", 64'(rd_w[u]), 64'd0);
    chk("rst_busy", 64'(busy_w[u]), 64'd0);
    chk("rst_ram_addr", 64'(raddr_w[u]), 64'd0);
    chk("rst_rsp_rdata", rdata_w[u], 64'd0);
  endtask

  task automatic stream(input int u, input bit we, input int first, input int cnt,
                        input int gap);
    int acc, prev;
    prev = -1;
    for (int i = 0; i < cnt; i++) begin
      send(u, we, AW'(first + i), {$urandom(), $urandom()}, 1'b1, acc);
      if (prev >= 0) chk(we ? "wr_gap" : "rd_gap", 64'(acc - prev), 64'(gap));
      prev = acc;
    end
    idle(u);
    drain(u);
  endtask

  task automatic random_ops(input int u);
    int acc;
    for (int a = 0; a < 16; a++) send(u, 1'b1, AW'(a), {$urandom(), $urandom()}, 1'b1, acc);
    idle(u);
    rr_rand[u] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(u, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           {$urandom(), $urandom()}, 1'b1, acc);
      if ($urandom_range(0, 3) == 0) begin
        idle(u);
        step();
      end
    end
    idle(u);
    drain(u);
    rr_rand[u] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int n;
    rst = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    rr_rand[0] = 1'b0;
    rr_rand[1] = 1'b0;
    rr_val[0] = 1'b1;
    rr_val[1] = 1'b1;

    // Reset held with random request traffic.
    for (int i = 0; i < 5; i++) begin
      step();
      req_valid = 2'($urandom_range(0, 3));
      req_we    = 2'($urandom_range(0, 3));
      #1;
      chk_reset_outputs(0);
      chk_reset_outputs(1);
    end
    step();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rel_req_ready0", 64'(req_ready_w[0]), 64'd1);
    chk("rel_req_ready1", 64'(req_ready_w[1]), 64'd1);
    step();

    // Write then read.
    send(0, 1'b1, 8'h12, 64'hDEADBEEF_00000001, 1'b1, acc);
    idle(0);
    drain(0);
    send(0, 1'b0, 8'h12, '0, 1'b1, acc);
    idle(0);
    drain(0);
    chk("rd_0x12_value", model_mem[0][8'h12], 64'hDEADBEEF_00000001);

    // Response backpressure for 5 cycles.
    rr_val[0] = 1'b0;
    step();
    send(0, 1'b0, 8'h12, '0, 1'b1, acc);
    idle(0);
    n = 0;
    while (!rsp_valid_w[0] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail("rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", 64'(req_ready_w[0]), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid_w[0]), 64'd1);
      chk("stall_rdata", rdata_w[0], 64'hDEADBEEF_00000001);
      step();
    end
    rr_val[0] = 1'b1;
    step();
    chk("post_rsp_busy", 64'(busy_w[0]), 64'd0);
    chk("post_rsp_ready", 64'(req_ready_w[0]), 64'd1);

    // Back-to-back streams with req_valid held high.
    stream(0, 1'b1, 0, 8, 2);
    stream(0, 1'b0, 0, 8, 4);
    send(0, 1'b1, 8'h03, 64'h0123_4567_89AB_CDEF, 1'b1, acc);
    send(0, 1'b0, 8'h03, '0, 1'b1, acc);
    idle(0);
    drain(0);

    // Three extra read wait cycles.
    send(1, 1'b1, 8'h05, 64'hCAFE_F00D_5555_AAAA, 1'b1, acc);
    idle(1);
    drain(1);
    stream(1, 1'b0, 5, 3, 7);

    // Randomized mixes with random backpressure.
    random_ops(0);
    random_ops(1);

    // Reset during WR: the RAM word must keep its old value.
    send(0, 1'b1, 8'h20, 64'h1111_2222_3333_4444, 1'b1, acc);
    idle(0);
    drain(0);
    send(0, 1'b1, 8'h20, 64'h9999_8888_7777_6666, 1'b0, acc);
    idle(0);
    rst = 1'b0;
    #1;
    chk("wr_abort_wr_en", 64'(wr_w[0]), 64'd0);
    chk("wr_abort_busy", 64'(busy_w[0]), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();
    send(0, 1'b0, 8'h20, '0, 1'b1, acc);
    idle(0);
    drain(0);

    // Reset during RD_CAP: no response may appear.
    send(0, 1'b0, 8'h12, '0, 1'b0, acc);
    idle(0);
    step();
    rst = 1'b0;
    #1;
    chk("rd_abort_rd_en", 64'(rd_w[0]), 64'd0);
    chk("rd_abort_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
    chk("rd_abort_busy", 64'(busy_w[0]), 64'd0);
    chk("rd_abort_rdata", rdata_w[0], 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    send(0, 1'b0, 8'h12, '0, 1'b1, acc);
    idle(0);
    drain(0);

    for (int u = 0; u < 2; u++) begin
      chk("left_rd", 64'(exp_q[u].size()), 64'd0);
      chk("left_wr", 64'(wr_exp_q[u].size()), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time limit.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Single-master request controller that sits directly upstream of the tri-state RAM and is its only bus driver.
- Converts a valid/ready request channel (read or write) into that RAM's addr / wr_en / rd_en / bidirectional data protocol.
- Returns read data on a valid/ready response channel that accepts backpressure.
- Guarantees no bus contention and no simultaneous wr_en/rd_en.

Parameters:
- ADDR_W, 8: RAM address width; must match the RAM address bus macro.
- DATA_W, 64: RAM data width; must match the RAM data bus macro.
- RD_WAIT_CYC, 0: extra cycles rd_en is held between RAM register load and capture (0..15). Used for slower RAM variants.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdata  out  DATA_W  read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_en  out  1  RAM read enable.
- ram_data  inout  DATA_W  shared RAM data bus.
- busy  out  1  controller not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_wr_en=0, ram_rd_en=0, ram_data released to Z, busy=0, wait counter=0.
- Reset mid-transaction: the transaction is dropped, no response, and no RAM write occurs after reset asserts.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RD_CAP, RSP.
- req_ready is 1 only in IDLE (and rst=1); it is combinational from state.
- Accept: req_valid && req_ready at a posedge. On accept, latch req_addr into ram_addr, latch req_wdata into a write register, and branch on req_we: WR or RD_REQ.
- IDLE: req_valid=0 stays in IDLE. All RAM enables are 0 and the bus is Z.
- WR, 1 cycle:
  - Outputs: ram_wr_en=1, ram_rd_en=0, ram_data driven with the write register.
  - Next state: IDLE.
  - RAM stores at the end of this cycle.
  - Writes are posted: no response. Max write throughput is 1 per 2 cycles.
- RD_REQ, 1 cycle:
  - Outputs: ram_rd_en=1, ram_wr_en=0, ram_data=Z. The RAM loads its output register at the end of this cycle.
  - Next state: RD_WAIT if RD_WAIT_CYC>0, else RD_CAP.
- RD_WAIT:
  - Outputs: ram_rd_en=1.
  - Counter runs from RD_WAIT_CYC-1 down to 0, then RD_CAP.
- RD_CAP, 1 cycle:
  - Outputs: ram_rd_en=1.
  - rsp_rdata <= ram_data at the end of the cycle, then RSP.
- RSP:
  - Outputs: ram_rd_en=0, rsp_valid=1.
  - rsp_rdata is held stable until rsp_ready=1 at a posedge, then IDLE.
  - rsp_ready=0 stalls indefinitely; no new request is accepted while stalled.
  - rsp_valid is registered-state based and never depends combinationally on rsp_ready.
- Read latency: accept at edge E gives rsp_valid=1 in the cycle after edge E+2+RD_WAIT_CYC.
  - Minimum request-to-response turnaround is 3 cycles.
  - Read throughput is 1 per (4+RD_WAIT_CYC) cycles with rsp_ready tied high.
- Bus rules (invariants):
  - ram_data is driven by this block only in WR; it is Z otherwise.
  - ram_wr_en && ram_rd_en is never 1.
  - At least one cycle with ram_rd_en=0 (RSP/IDLE) precedes any WR, which provides a turnaround cycle.
- Address hold: ram_addr is constant from accept until return to IDLE.
- Stable inputs: req_* may change freely after accept; only latched copies are used.
- busy = (state != IDLE).
- Widths: no arithmetic on data. The wait counter is 4 bits; RD_WAIT_CYC>15 is illegal and flagged by a simulation-only check.

Test Plan:
- Reset check: hold rst=0 with random req_valid -> all outputs 0, ram_data=Z, req_ready=0. Release rst -> req_ready=1 on the next cycle.
- Write then read:
  - Write addr 0x12, data 0xDEADBEEF_00000001 -> exactly 1 cycle of ram_wr_en=1 with bus=data.
  - Read 0x12 -> rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF_00000001.
- Response backpressure: read 0x12 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. rsp_ready=1 -> IDLE next cycle.
- Back-to-back streams with req_valid held high:
  - Writes to 0x00..0x07 -> one accept every 2 cycles, 8 wr_en pulses.
  - Read-after-write to the same addr -> new data returned.
  - Assertion: no cycle with wr_en&rd_en, and no cycle with both the block and the RAM driving the bus.
- RD_WAIT_CYC=3: read 0x05 -> ram_rd_en high for 5 consecutive cycles, rsp_valid 6 cycles after accept, correct data.
- Reset mid-operation: assert rst in RD_CAP and in WR -> outputs clear immediately, no rsp_valid. A write interrupted by reset does not alter the RAM word (verified by a read-back after reset).
